mul8_share_ctrl: RTL and testbench



---
 rtl/mul8_share_ctrl_pkg.sv | 21 ++
 rtl/mul8_share_ctrl_nib_pass_sel.sv | 20 ++
 rtl/wallace.sv | 19 +
 rtl/mul8_share_ctrl.sv | 134 +++++++++++++
 tb/tb_mul8_share_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul8_share_ctrl_pkg.sv
// Shared constants and operand payload for the shared-multiplier controller.
package mul8_share_ctrl_pkg;

   localparam int unsigned OPND_W   = 8;
   localparam int unsigned NIB_W    = 4;
   localparam int unsigned PASS_CNT = 4;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned PROD_W   = 2 * OPND_W;
   localparam int unsigned SHIFT_W  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic              id;
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
   } op_t;

endpackage

// File: rtl/mul8_share_ctrl_nib_pass_sel.sv
// Picks the operand nibbles and accumulation shift for the current pass.
module mul8_share_ctrl_nib_pass_sel
   import mul8_share_ctrl_pkg::*;
(
   input  logic [CNT_W-1:0]   cnt,
   input  logic [OPND_W-1:0]  opa,
   input  logic [OPND_W-1:0]  opb,
   output logic [NIB_W-1:0]   nib_a_c,
   output logic [NIB_W-1:0]   nib_b_c,
   output logic [SHIFT_W-1:0] shamt_c
);

   // cnt[0] selects the A nibble, cnt[1] the B nibble
   always_comb begin
      nib_a_c = cnt[0] ? opa[2*NIB_W-1:NIB_W] : opa[NIB_W-1:0];
      nib_b_c = cnt[1] ? opb[2*NIB_W-1:NIB_W] : opb[NIB_W-1:0];
      shamt_c = SHIFT_W'(NIB_W) * (SHIFT_W'(cnt[0]) + SHIFT_W'(cnt[1]));
   end

endmodule

// File: rtl/wallace.sv
// Unsigned 4x4 multiplier cell, combinational.
module wallace
   import mul8_share_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0]   a,
   input  logic [NIB_W-1:0]   b,
   output logic [2*NIB_W-1:0] p_c
);

   always_comb begin
      p_c = '0;
      for (int i = 0; i < NIB_W; i++) begin
         if (b[i]) begin
            p_c = p_c + ((2*NIB_W)'(a) << i);
         end
      end
   end

endmodule

// File: rtl/mul8_share_ctrl.sv
// Two-requester round-robin front end for an 8x8 multiply built from four
// passes through a single shared 4x4 cell.
module mul8_share_ctrl
   import mul8_share_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIRST_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_W-1:0]     req0_a,
   input  logic [DATA_W-1:0]     req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_W-1:0]     req1_a,
   input  logic [DATA_W-1:0]     req1_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*DATA_W-1:0]   res_prod,
   output logic                  res_id,
   output logic                  busy
);

   logic [1:0]        state_q, state_d;
   logic              prio_q, prio_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   op_t               op_q, op_d;
   logic              res_valid_q, res_valid_d;
   logic [PROD_W-1:0] res_prod_q, res_prod_d;
   logic              res_id_q, res_id_d;

   logic              grant0_c, grant1_c;
   logic [NIB_W-1:0]  nib_a_c, nib_b_c;
   logic [SHIFT_W-1:0] shamt_c;
   logic [2*NIB_W-1:0] nib_prod_c;
   logic [PROD_W-1:0] partial_c;

   mul8_share_ctrl_nib_pass_sel u_nib_pass_sel (
      .cnt     (cnt_q),
      .opa     (op_q.a),
      .opb     (op_q.b),
      .nib_a_c (nib_a_c),
      .nib_b_c (nib_b_c),
      .shamt_c (shamt_c)
   );

   wallace u_wallace (
      .a   (nib_a_c),
      .b   (nib_b_c),
      .p_c (nib_prod_c)
   );

   assign partial_c = PROD_W'(nib_prod_c) << shamt_c;

   // Next-state, arbitration and accumulation
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      op_d        = op_q;
      res_valid_d = res_valid_q;
      res_prod_d  = res_prod_q;
      res_id_d    = res_id_q;
      grant0_c    = 1'b0;
      grant1_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant0_c = rst_n && req0_valid && (!prio_q || !req1_valid);
            grant1_c = rst_n && req1_valid && ( prio_q || !req0_valid);
            if (grant0_c || grant1_c) begin
               op_d.id = grant1_c;
               op_d.a  = grant1_c ? req1_a : req0_a;
               op_d.b  = grant1_c ? req1_b : req0_b;
               acc_d   = '0;
               cnt_d   = '0;
               prio_d  = !grant1_c;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = acc_q + partial_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(PASS_CNT - 1)) begin
               res_prod_d  = acc_q + partial_c;
               res_id_d    = op_q.id;
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         prio_q      <= 1'(FIRST_PRIO);
         cnt_q       <= '0;
         acc_q       <= '0;
         op_q        <= '0;
         res_valid_q <= 1'b0;
         res_prod_q  <= '0;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         res_valid_q <= res_valid_d;
         res_prod_q  <= res_prod_d;
         res_id_q    <= res_id_d;
      end
   end

   assign req0_ready = grant0_c;
   assign req1_ready = grant1_c;
   assign res_valid  = res_valid_q;
   assign res_prod   = res_prod_q;
   assign res_id     = res_id_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul8_share_ctrl.sv
// Randomised and directed bench for mul8_share_ctrl against a transaction-level
// model of arbitration, latency and products.
module tb_mul8_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic        res_valid, res_ready, res_id, busy;
   logic [15:0] res_prod;

   always #5 clk = ~clk;

   mul8_share_ctrl #(.DATA_W(8), .FIRST_PRIO(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_prod   (res_prod),
      .res_id     (res_id),
      .busy       (busy)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_res    = 0;
   int          g_cnt [2];

   // reference model: unit free flag, pointer, one outstanding job
   bit          m_idle, m_prio, m_job, m_job_id, m_out_id;
   logic [15:0] m_job_prod, m_out_prod;
   int          m_job_due;
   bit          full_load, have_last, last_id;

   bit          s_r0, s_r1, s_rv, s_id, s_busy, hs0, hs1;
   logic [15:0] s_prod;

   task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst_n      = 1'b0;
         req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
         req1_valid = 1'b1; req1_a = rnd_op(); req1_b = rnd_op();
         res_ready  = 1'b0;
         @(negedge clk);
         check_eq("rst_rdy0", 16'(req0_ready), 16'(1'b0));
         check_eq("rst_rdy1", 16'(req1_ready), 16'(1'b0));
         cyc++;
      end
      m_idle = 1'b1; m_prio = 1'b0; m_job = 1'b0;
      m_out_prod = 16'h0000; m_out_id = 1'b0; have_last = 1'b0;
   endtask

   task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                       input logic rr);
      bit exp_r0, exp_r1, exp_rv;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      res_ready  = rr;
      @(negedge clk);
      exp_rv = m_job && (cyc >= m_job_due);
      if (exp_rv) begin
         m_out_prod = m_job_prod;
         m_out_id   = m_job_id;
      end
      exp_r0 = m_idle && v0 && (!m_prio || !v1);
      exp_r1 = m_idle && v1 && ( m_prio || !v0);
      s_r0 = req0_ready; s_r1 = req1_ready; s_rv = res_valid;
      s_id = res_id; s_busy = busy; s_prod = res_prod;
      check_eq("req0_ready", 16'(s_r0), 16'(exp_r0));
      check_eq("req1_ready", 16'(s_r1), 16'(exp_r1));
      check_eq("res_valid", 16'(s_rv), 16'(exp_rv));
      check_eq("busy", 16'(s_busy), 16'(!m_idle));
      check_eq("res_prod", s_prod, m_out_prod);
      check_eq("res_id", 16'(s_id), 16'(m_out_id));
      hs0 = exp_r0; hs1 = exp_r1;
      if (exp_rv && rr) begin
         m_job  = 1'b0;
         m_idle = 1'b1;
         n_res++;
      end
      if (exp_r0 || exp_r1) begin
         m_idle     = 1'b0;
         m_job      = 1'b1;
         m_job_id   = exp_r1;
         m_job_prod = exp_r1 ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
         m_job_due  = cyc + 5;
         m_prio     = !exp_r1;
         g_cnt[exp_r1 ? 1 : 0]++;
         if (full_load && have_last)
            check_eq("alternate", 16'(exp_r1), 16'(!last_id));
         have_last = 1'b1;
         last_id   = exp_r1;
      end
      cyc++;
   endtask

   task automatic idle_step(input logic rr);
      step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, rr);
   endtask

   task automatic run_random(input int target, input bit load);
      bit         v0, v1;
      logic [7:0] a0, b0, a1, b1;
      int         start, guard;
      start = n_res;
      guard = 0;
      v0 = load || ($urandom_range(0, 1) == 1); a0 = rnd_op(); b0 = rnd_op();
      v1 = load || ($urandom_range(0, 1) == 1); a1 = rnd_op(); b1 = rnd_op();
      while ((n_res - start) < target && guard < 20000) begin
         step(v0, a0, b0, v1, a1, b1, $urandom_range(0, 3) != 0);
         if (hs0 || !v0) begin
            v0 = load || ($urandom_range(0, 1) == 1); a0 = rnd_op(); b0 = rnd_op();
         end
         if (hs1 || !v1) begin
            v1 = load || ($urandom_range(0, 1) == 1); a1 = rnd_op(); b1 = rnd_op();
         end
         guard++;
      end
      check_eq("rand_done", 16'((n_res - start) >= target), 16'(1'b1));
   endtask

   initial begin
      int diff;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
      g_cnt[0] = 0; g_cnt[1] = 0;
      do_reset(2);

      // single request and 5-cycle latency
      step(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1);
      check_eq("single_rdy", 16'(s_r0), 16'(1'b1));
      repeat (4) idle_step(1'b1);
      idle_step(1'b1);
      check_eq("single_valid", 16'(s_rv), 16'(1'b1));
      check_eq("single_prod", s_prod, 16'h03A8);
      check_eq("single_id", 16'(s_id), 16'(1'b0));

      // max operands on req1
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1);
      check_eq("max_rdy", 16'(s_r1), 16'(1'b1));
      repeat (4) idle_step(1'b1);
      idle_step(1'b1);
      check_eq("max_prod", s_prod, 16'hFE01);
      check_eq("max_id", 16'(s_id), 16'(1'b1));

      // zero operand, same latency
      step(1'b1, 8'h00, 8'hAB, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (4) idle_step(1'b1);
      idle_step(1'b1);
      check_eq("zero_valid", 16'(s_rv), 16'(1'b1));
      check_eq("zero_prod", s_prod, 16'h0000);

      // contention right after reset
      do_reset(1);
      step(1'b1, 8'h0F, 8'h10, 1'b1, 8'h80, 8'h02, 1'b1);
      check_eq("cont_r0", 16'(s_r0), 16'(1'b1));
      check_eq("cont_r1", 16'(s_r1), 16'(1'b0));
      repeat (5) step(1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h02, 1'b1);
      check_eq("cont_prod0", s_prod, 16'h00F0);
      check_eq("cont_id0", 16'(s_id), 16'(1'b0));
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h02, 1'b1);
      check_eq("cont_r1_next", 16'(s_r1), 16'(1'b1));
      repeat (5) idle_step(1'b1);
      check_eq("cont_prod1", s_prod, 16'h0100);
      check_eq("cont_id1", 16'(s_id), 16'(1'b1));
      step(1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1);
      check_eq("cont_third", 16'(s_r0), 16'(1'b1));
      repeat (5) idle_step(1'b1);

      // backpressure on the result side
      step(1'b1, 8'h5A, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (4) idle_step(1'b0);
      repeat (3) begin
         step(1'b1, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1'b0);
         check_eq("bp_valid", 16'(s_rv), 16'(1'b1));
         check_eq("bp_prod", s_prod, 16'h3A02);
         check_eq("bp_rdy", 16'({s_r0, s_r1}), 16'(2'b00));
      end
      step(1'b1, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1'b1);
      check_eq("bp_consume_rdy", 16'({s_r0, s_r1}), 16'(2'b00));
      step(1'b1, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1'b1);
      check_eq("bp_idle_busy", 16'(s_busy), 16'(1'b0));
      check_eq("bp_idle_r1", 16'(s_r1), 16'(1'b1));
      repeat (5) idle_step(1'b1);

      // reset during pass 2
      step(1'b1, 8'hC3, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (2) idle_step(1'b1);
      do_reset(1);
      idle_step(1'b1);
      check_eq("abort_busy", 16'(s_busy), 16'(1'b0));
      check_eq("abort_valid", 16'(s_rv), 16'(1'b0));
      repeat (10) idle_step(1'b1);
      step(1'b1, 8'h07, 8'h09, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (5) idle_step(1'b1);
      check_eq("post_abort_prod", s_prod, 16'h003F);

      // full load fairness
      do_reset(1);
      full_load = 1'b1;
      g_cnt[0] = 0; g_cnt[1] = 0;
      run_random(300, 1'b1);
      diff = g_cnt[0] - g_cnt[1];
      check_eq("fairness", 16'(diff <= 1 && diff >= -1), 16'(1'b1));
      full_load = 1'b0;

      // mixed random traffic
      run_random(700, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
